// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the 5-stage core's hazard/forwarding control.
//   - FWD_* : EX operand mux select encodings (3-input mux, 2-bit select)
//   - hz_state_t : hazard sequencer FSM state encoding
//   - shadow_entry_t : one shadow pipeline slot (EX, MEM or WB)
// -----------------------------------------------------------------------------
package core_pkg;

  // Register address width that the shadow entries are built with.
  localparam int SHADOW_RA_W = 5;

  // EX operand mux select encoding. 2'b11 is never driven.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'b00,
    HZ_LU      = 2'b01,
    HZ_MD_BUSY = 2'b10
  } hz_state_t;

  // One shadow pipeline slot: what the real pipeline register holds, reduced
  // to the fields hazard detection and forwarding care about.
  typedef struct packed {
    logic                   v;
    logic [SHADOW_RA_W-1:0] rd;
    logic                   regwrite;
    logic                   memread;
    logic                   muldiv;
    logic [SHADOW_RA_W-1:0] rs1;
    logic [SHADOW_RA_W-1:0] rs2;
    logic                   rs1_used;
    logic                   rs2_used;
  } shadow_entry_t;

  localparam int SHADOW_ENTRY_W = $bits(shadow_entry_t);

  localparam shadow_entry_t SHADOW_NOP = '0;

endpackage

// File: rtl/fwd_sel_unit.sv
// -----------------------------------------------------------------------------
// fwd_sel_unit
//   Forward select for one EX source operand.
//   Ports:
//     rs, used                       EX source register and whether it is read
//     mem_v, mem_regwrite, mem_rd    MEM shadow entry write-port fields
//     wb_v,  wb_regwrite,  wb_rd     WB shadow entry write-port fields
//     sel                            FWD_MEM / FWD_WB / FWD_RF
//   MEM wins over WB because it holds the younger result. x0 never forwards.
// -----------------------------------------------------------------------------
module fwd_sel_unit
  import core_pkg::*;
#(
  parameter int RA_W = SHADOW_RA_W
) (
  input  logic [RA_W-1:0] rs,
  input  logic            used,
  input  logic            mem_v,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_v,
  input  logic            wb_regwrite,
  input  logic [RA_W-1:0] wb_rd,
  output logic [1:0]      sel
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_v && mem_regwrite && (mem_rd != '0) && (mem_rd == rs);
    wb_hit  = wb_v  && wb_regwrite  && (wb_rd  != '0) && (wb_rd  == rs);
    sel     = FWD_RF;
    if (used) begin
      if (mem_hit) begin
        sel = FWD_MEM;
      end else if (wb_hit) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Pipeline sequencer for the 5-stage core. Tracks a shadow EX/MEM/WB copy of
//   in-flight instructions, drives the EX forwarding mux selects, inserts
//   load-use bubbles, freezes the front end while a MUL/DIV is busy (with a
//   watchdog), and flushes on an EX redirect.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     id_*                     decoded fields of the instruction in ID;
//                              id_valid qualifies all other id_* fields, which
//                              are ignored while it is low
//     ex_redirect              taken branch/jump resolved in EX
//     muldiv_done              1-cycle result pulse from the MUL/DIV unit
//     fwd_a_sel, fwd_b_sel     EX operand mux selects
//     stall_if/id/ex           hold PC, IF/ID, ID/EX
//     flush_id, bubble_ex      zero IF/ID, load NOP into ID/EX
//     md_timeout               sticky watchdog expiry flag
//     stall_cnt                saturating count of stall_if cycles
//     dbg_state                current sequencer state
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
  import core_pkg::*;
#(
  parameter int RA_W       = SHADOW_RA_W,
  parameter int MD_MAX_CYC = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_muldiv,
  input  logic             ex_redirect,
  input  logic             muldiv_done,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output hz_state_t        dbg_state
);

  localparam int WD_W = (MD_MAX_CYC > 1) ? $clog2(MD_MAX_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYC - 1);

  hz_state_t       state_q, state_d;
  shadow_entry_t   ex_q, ex_d;
  shadow_entry_t   mem_q, mem_d;
  shadow_entry_t   wb_q, wb_d;
  shadow_entry_t   id_entry;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            load_use;

  // WB keeps the full entry so it mirrors the real pipeline; only its write
  // port fields feed forwarding.
  logic wb_unused;
  assign wb_unused = ^{wb_q.memread, wb_q.muldiv, wb_q.rs1, wb_q.rs2,
                       wb_q.rs1_used, wb_q.rs2_used};

  // An invalid ID slot enters EX as a clean NOP so stale source fields never
  // produce forward selects.
  always_comb begin
    id_entry = SHADOW_NOP;
    if (id_valid) begin
      id_entry.v        = 1'b1;
      id_entry.rd       = id_rd;
      id_entry.regwrite = id_regwrite;
      id_entry.memread  = id_memread;
      id_entry.muldiv   = id_muldiv;
      id_entry.rs1      = id_rs1;
      id_entry.rs2      = id_rs2;
      id_entry.rs1_used = id_rs1_used;
      id_entry.rs2_used = id_rs2_used;
    end
  end

  always_comb begin
    load_use = ex_q.v && ex_q.memread && (ex_q.rd != '0) && id_valid &&
               ((id_rs1_used && (id_rs1 == ex_q.rd)) ||
                (id_rs2_used && (id_rs2 == ex_q.rd)));
  end

  // Sequencer next-state and control outputs.
  always_comb begin
    state_d      = state_q;
    wd_d         = '0;
    md_timeout_d = md_timeout_q;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    flush_id     = 1'b0;
    bubble_ex    = 1'b0;
    case (state_q)
      HZ_RUN, HZ_LU: begin
        // LU only marks the cycle after a bubble; hazards are re-evaluated.
        state_d = HZ_RUN;
        if (ex_redirect) begin
          // Wrong-path ID instruction is squashed, so a pending load-use on
          // it is moot.
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          state_d   = HZ_LU;
        end else if (ex_q.v && ex_q.muldiv) begin
          state_d = HZ_MD_BUSY;
        end
      end
      HZ_MD_BUSY: begin
        if (muldiv_done) begin
          // Stalls drop in the done cycle so EX advances on this edge.
          state_d = HZ_RUN;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          if (wd_q == WD_LAST) begin
            md_timeout_d = 1'b1;
            state_d      = HZ_RUN;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      default: begin
        state_d = HZ_RUN;
      end
    endcase
  end

  // Shadow pipeline advance. A held EX sends a NOP into MEM.
  always_comb begin
    wb_d = mem_q;
    if (stall_ex) begin
      ex_d  = ex_q;
      mem_d = SHADOW_NOP;
    end else begin
      mem_d = ex_q;
      ex_d  = bubble_ex ? SHADOW_NOP : id_entry;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HZ_RUN;
      ex_q         <= SHADOW_NOP;
      mem_q        <= SHADOW_NOP;
      wb_q         <= SHADOW_NOP;
      wd_q         <= '0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      wd_q         <= wd_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  fwd_sel_unit #(.RA_W(RA_W)) u_fwd_a (
    .rs           (ex_q.rs1),
    .used         (ex_q.rs1_used),
    .mem_v        (mem_q.v),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb_v         (wb_q.v),
    .wb_regwrite  (wb_q.regwrite),
    .wb_rd        (wb_q.rd),
    .sel          (fwd_a_sel)
  );

  fwd_sel_unit #(.RA_W(RA_W)) u_fwd_b (
    .rs           (ex_q.rs2),
    .used         (ex_q.rs2_used),
    .mem_v        (mem_q.v),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb_v         (wb_q.v),
    .wb_regwrite  (wb_q.regwrite),
    .wb_rd        (wb_q.rd),
    .sel          (fwd_b_sel)
  );

  assign md_timeout = md_timeout_q;
  assign stall_cnt  = stall_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//   Directed bench for hazard_fwd_ctrl. The bench plays IF/ID: it presents one
//   decoded instruction per cycle and keeps it while stall_id is high.
//   Inputs change 1 time unit after the rising edge; outputs are checked one
//   more unit later.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;
  import core_pkg::*;

  localparam int RA_W       = 5;
  localparam int MD_MAX_CYC = 64;
  localparam int CNT_W      = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid;
  logic [RA_W-1:0]  id_rs1, id_rs2, id_rd;
  logic             id_rs1_used, id_rs2_used;
  logic             id_regwrite, id_memread, id_muldiv;
  logic             ex_redirect;
  logic             muldiv_done;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             stall_if, stall_id, stall_ex, flush_id, bubble_ex;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cnt;
  hz_state_t        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .RA_W(RA_W), .MD_MAX_CYC(MD_MAX_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_muldiv(id_muldiv), .ex_redirect(ex_redirect), .muldiv_done(muldiv_done),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .bubble_ex(bubble_ex), .md_timeout(md_timeout),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // The instruction held in EX during MD_BUSY is never a branch.
  always @(negedge clk) begin
    if (!rst && dbg_state == HZ_MD_BUSY) begin
      assert (!ex_redirect);
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_fwd_a"},    32'(fwd_a_sel), 0);
    check_eq({tag, "_fwd_b"},    32'(fwd_b_sel), 0);
    check_eq({tag, "_stall_if"}, 32'(stall_if),  0);
    check_eq({tag, "_stall_id"}, 32'(stall_id),  0);
    check_eq({tag, "_stall_ex"}, 32'(stall_ex),  0);
    check_eq({tag, "_flush"},    32'(flush_id),  0);
    check_eq({tag, "_bubble"},   32'(bubble_ex), 0);
    check_eq({tag, "_timeout"},  32'(md_timeout), 0);
    check_eq({tag, "_cnt"},      32'(stall_cnt), 0);
    check_eq({tag, "_state"},    32'(dbg_state), 32'(HZ_RUN));
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_id();
    id_valid    = 1'b0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    id_rd       = '0;
    id_regwrite = 1'b0;
    id_memread  = 1'b0;
    id_muldiv   = 1'b0;
  endtask

  task automatic drive_id(input logic [RA_W-1:0] rs1, input logic u1,
                          input logic [RA_W-1:0] rs2, input logic u2,
                          input logic [RA_W-1:0] rd, input logic rw,
                          input logic mr, input logic md);
    id_valid    = 1'b1;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_muldiv   = md;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_id();
    ex_redirect = 1'b0;
    muldiv_done = 1'b0;
    tick();
    tick();
    settle();
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_id();
    ex_redirect = 1'b0;
    muldiv_done = 1'b0;
    do_reset();

    // add x5 in MEM, EX consumer reads x5 as rs1 and x7 as rs2.
    drive_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0); tick();
    drive_id(5'd5, 1, 5'd7, 1, 5'd9, 1, 0, 0); tick();
    idle_id(); settle();
    check_eq("t1_fwd_a_mem", 32'(fwd_a_sel), 2);
    check_eq("t1_fwd_b_rf",  32'(fwd_b_sel), 0);
    check_eq("t1_no_stall",  32'(stall_if),  0);

    // x5 written by both MEM and WB: MEM has priority.
    drive_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0); tick();
    drive_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0); tick();
    drive_id(5'd3, 1, 5'd5, 1, 5'd10, 1, 0, 0); tick();
    idle_id(); settle();
    check_eq("t2_fwd_b_mem_prio", 32'(fwd_b_sel), 2);
    check_eq("t2_fwd_a_rf",       32'(fwd_a_sel), 0);

    // Only WB writes x5; rs1 also x5 but unused.
    drive_id(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0); tick();
    drive_id(5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0); tick();
    drive_id(5'd5, 0, 5'd5, 1, 5'd11, 1, 0, 0); tick();
    idle_id(); settle();
    check_eq("t2_fwd_b_wb",     32'(fwd_b_sel), 1);
    check_eq("t2_fwd_a_unused", 32'(fwd_a_sel), 0);

    // x0 destinations never forward.
    drive_id(5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0); tick();
    drive_id(5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0); tick();
    drive_id(5'd0, 1, 5'd0, 1, 5'd12, 1, 0, 0); tick();
    idle_id(); settle();
    check_eq("t4_x0_fwd_a", 32'(fwd_a_sel), 0);
    check_eq("t4_x0_fwd_b", 32'(fwd_b_sel), 0);

    // lw x0 in EX with an x0 reader in ID: no load-use.
    drive_id(5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0); tick();
    drive_id(5'd0, 1, 5'd0, 1, 5'd13, 1, 0, 0); settle();
    check_eq("t4_x0_no_stall",  32'(stall_if),  0);
    check_eq("t4_x0_no_bubble", 32'(bubble_ex), 0);
    tick();

    // lw x6 in EX; first an invalid ID slot, then a real x6 reader.
    drive_id(5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0); tick();
    drive_id(5'd6, 1, 5'd2, 1, 5'd7, 1, 0, 0);
    id_valid = 1'b0; settle();
    check_eq("t3_invalid_no_stall", 32'(stall_if), 0);
    id_valid = 1'b1; settle();
    check_eq("t3_lu_stall_if", 32'(stall_if),  1);
    check_eq("t3_lu_stall_id", 32'(stall_id),  1);
    check_eq("t3_lu_bubble",   32'(bubble_ex), 1);
    check_eq("t3_lu_stall_ex", 32'(stall_ex),  0);
    tick();  // ID held by the bench
    settle();
    check_eq("t3_lu_state",    32'(dbg_state), 32'(HZ_LU));
    check_eq("t3_lu_released", 32'(stall_if),  0);
    check_eq("t3_lu_no_bubble", 32'(bubble_ex), 0);
    check_eq("t3_stall_cnt",   32'(stall_cnt), 1);
    tick();
    idle_id(); settle();
    // The load has reached WB by the time the consumer enters EX.
    check_eq("t3_consumer_fwd_a", 32'(fwd_a_sel), 1);
    check_eq("t3_consumer_fwd_b", 32'(fwd_b_sel), 0);
    check_eq("t3_back_to_run",    32'(dbg_state), 32'(HZ_RUN));

    // Redirect coincident with load-use.
    drive_id(5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0); tick();
    drive_id(5'd2, 1, 5'd6, 1, 5'd7, 1, 0, 0);
    ex_redirect = 1'b1; settle();
    check_eq("t6_redir_flush",    32'(flush_id),  1);
    check_eq("t6_redir_bubble",   32'(bubble_ex), 1);
    check_eq("t6_redir_stall_if", 32'(stall_if),  0);
    check_eq("t6_redir_stall_id", 32'(stall_id),  0);
    tick();
    ex_redirect = 1'b0; idle_id(); settle();
    check_eq("t6_redir_state", 32'(dbg_state), 32'(HZ_RUN));
    check_eq("t6_redir_cnt",   32'(stall_cnt), 1);

    // div in EX, done after 10 busy cycles.
    do_reset();
    drive_id(5'd1, 1, 5'd2, 1, 5'd8, 1, 0, 1); tick();
    idle_id(); settle();
    check_eq("t5_div_ex_no_stall", 32'(stall_ex), 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      settle();
      check_eq("t5_md_stall_ex", 32'(stall_ex), 1);
      tick();
    end
    muldiv_done = 1'b1; settle();
    check_eq("t5_done_stall_ex", 32'(stall_ex),  0);
    check_eq("t5_done_stall_if", 32'(stall_if),  0);
    check_eq("t5_stall_cnt",     32'(stall_cnt), 10);
    tick();
    muldiv_done = 1'b0; settle();
    check_eq("t5_done_state", 32'(dbg_state), 32'(HZ_RUN));
    check_eq("t5_no_timeout", 32'(md_timeout), 0);

    // div with no done: watchdog expires after 64 busy cycles.
    drive_id(5'd1, 1, 5'd2, 1, 5'd8, 1, 0, 1); tick();
    idle_id(); tick();
    repeat (63) tick();
    settle();
    check_eq("t5_wd_last_state",   32'(dbg_state),  32'(HZ_MD_BUSY));
    check_eq("t5_wd_last_timeout", 32'(md_timeout), 0);
    tick();
    settle();
    check_eq("t5_wd_state",    32'(dbg_state),  32'(HZ_RUN));
    check_eq("t5_wd_timeout",  32'(md_timeout), 1);
    check_eq("t5_wd_stall_ex", 32'(stall_ex),   0);
    check_eq("t5_wd_cnt",      32'(stall_cnt),  74);

    // Reset while in MD_BUSY.
    drive_id(5'd1, 1, 5'd2, 1, 5'd8, 1, 0, 1); tick();
    idle_id(); tick();
    repeat (3) tick();
    settle();
    check_eq("t6_pre_rst_stall_ex", 32'(stall_ex), 1);
    rst = 1'b1;
    tick();
    settle();
    check_all_zero("t6_rst_md");
    rst = 1'b0;
    tick();
    settle();
    check_eq("t6_post_rst_stall_if", 32'(stall_if), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
